// File: rtl/game_pkg.sv
// Shared types and constants for the memorization game: sequencer state encoding,
// pattern sizing and the LED one-hot decoder.
package game_pkg;

    localparam int LED_COUNT = 4;
    localparam int LED_IDX_W = 2;
    localparam int MAX_LEN   = 16;
    localparam int LEN_W     = 5;
    localparam int STEP_W    = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        SHOW = 2'd2,
        GAP  = 2'd3
    } seqState_e;

    function automatic logic [LED_COUNT-1:0] onehot_led(input logic [LED_IDX_W-1:0] idx);
        logic [LED_COUNT-1:0] vec;
        vec      = {LED_COUNT{1'b0}};
        vec[idx] = 1'b1;
        return vec;
    endfunction

endpackage

// File: rtl/pattern_sequencer_tick_gen.sv
// Two-flop synchronizer plus registered rising-edge detector for a slow divided clock
// level; emits a one-cycle tick three clk cycles after the source rises.
module tick_gen (
    input  logic clk,
    input  logic rst,
    input  logic blinkClk,
    output logic tick
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;

    // Synchronizer chain and edge register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            tick    <= 1'b0;
        end else begin
            sync1_r <= blinkClk;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            tick    <= sync2_r & ~prev_r;
        end
    end

endmodule

// File: rtl/pattern_sequencer.sv
// LED pattern playback controller, stepped by synchronized blinkClk ticks.
// Define PATTERN_GAP_EN to insert a blank GAP phase between consecutive steps.
module pattern_sequencer #(
    parameter int NUM_LEDS = 32'd4,
    parameter int MAX_LEN  = 32'd16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  blinkClk,
    input  logic                  start,
    input  logic                  abort,
    input  logic [4:0]            length,
    input  logic [2*MAX_LEN-1:0]  pattern,
    output logic [NUM_LEDS-1:0]   led,
    output logic                  busy,
    output logic                  done,
    output logic [3:0]            step
);

    import game_pkg::*;

    localparam logic [LEN_W-1:0] MAX_LEN_V = LEN_W'(MAX_LEN);

    logic                 tick_s;
    seqState_e            state_r;
    seqState_e            nextState_s;
    logic [LEN_W-1:0]     len_r;
    logic [LEN_W-1:0]     nextLen_s;
    logic [STEP_W-1:0]    nextStep_s;
    logic                 nextBusy_s;
    logic                 nextDone_s;
    logic                 lastStep_s;
    logic [LED_IDX_W-1:0] ledIdx_s;
    logic [NUM_LEDS-1:0]  nextLed_s;

    tick_gen uTickGen (
        .clk      (clk),
        .rst      (rst),
        .blinkClk (blinkClk),
        .tick     (tick_s)
    );

    // Next-state, next-output decode; abort overrides everything
    always_comb begin
        nextState_s = state_r;
        nextLen_s   = len_r;
        nextStep_s  = step;
        nextBusy_s  = busy;
        nextDone_s  = 1'b0;
        lastStep_s  = ({1'b0, step} == (len_r - 5'd1));

        if (abort) begin
            nextState_s = IDLE;
            nextStep_s  = 4'd0;
            nextBusy_s  = 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (start) begin
                        nextState_s = SYNC;
                        nextStep_s  = 4'd0;
                        nextBusy_s  = 1'b1;
                        nextLen_s   = (length > MAX_LEN_V) ? MAX_LEN_V : length;
                    end else begin
                        nextState_s = IDLE;
                    end
                end
                SYNC: begin
                    // An empty pattern completes without waiting for a tick
                    if (len_r == 5'd0) begin
                        nextState_s = IDLE;
                        nextBusy_s  = 1'b0;
                        nextDone_s  = 1'b1;
                    end else if (tick_s) begin
                        nextState_s = SHOW;
                    end else begin
                        nextState_s = SYNC;
                    end
                end
                SHOW: begin
                    if (tick_s) begin
`ifdef PATTERN_GAP_EN
                        nextState_s = GAP;
`else
                        if (lastStep_s) begin
                            nextState_s = IDLE;
                            nextStep_s  = 4'd0;
                            nextBusy_s  = 1'b0;
                            nextDone_s  = 1'b1;
                        end else begin
                            nextState_s = SHOW;
                            nextStep_s  = step + 4'd1;
                        end
`endif
                    end else begin
                        nextState_s = SHOW;
                    end
                end
                GAP: begin
`ifdef PATTERN_GAP_EN
                    if (tick_s && lastStep_s) begin
                        nextState_s = IDLE;
                        nextStep_s  = 4'd0;
                        nextBusy_s  = 1'b0;
                        nextDone_s  = 1'b1;
                    end else if (tick_s) begin
                        nextState_s = SHOW;
                        nextStep_s  = step + 4'd1;
                    end else begin
                        nextState_s = GAP;
                    end
`else
                    nextState_s = IDLE;
                    nextStep_s  = 4'd0;
                    nextBusy_s  = 1'b0;
`endif
                end
                default: begin
                    nextState_s = IDLE;
                    nextStep_s  = 4'd0;
                    nextBusy_s  = 1'b0;
                end
            endcase
        end

        // LED drive follows the state being entered so it is registered with it
        ledIdx_s = pattern[{nextStep_s, 1'b0} +: LED_IDX_W];
        if (nextState_s == SHOW) begin
            nextLed_s = onehot_led(ledIdx_s);
        end else begin
            nextLed_s = {NUM_LEDS{1'b0}};
        end
    end

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
            len_r   <= 5'd0;
            step    <= 4'd0;
            busy    <= 1'b0;
            done    <= 1'b0;
            led     <= {NUM_LEDS{1'b0}};
        end else begin
            state_r <= nextState_s;
            len_r   <= nextLen_s;
            step    <= nextStep_s;
            busy    <= nextBusy_s;
            done    <= nextDone_s;
            led     <= nextLed_s;
        end
    end

endmodule
